mem_seq_master: RTL and testbench
=================================

// Module: mem_seq_master
// PURPOSE
//  Initiator side of the coprocessor's single-word memory handshake
//  (start/wr/address/data_in -> data_out/done). Takes one block command
//  (base address, word count, read/write) and runs one four-phase handshake
//  per word. Read words stream out; write words stream in. Sits between the
//  matrix load/store control and the memory wrapper.
// PARAMETERS
//  ADDR_W   8   memory address width
//  DATA_W   16  memory word width
//  LEN_W    8   word-count width
//  TIMEOUT  64  max cycles per handshake phase before abort (>=4)
// PORTS
//  clk            in   1       system clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  cmd_valid      in   1       command request
//  cmd_ready      out  1       high only in IDLE
//  cmd_wr         in   1       1=write block, 0=read block
//  cmd_addr       in   ADDR_W  base address
//  cmd_len        in   LEN_W   number of words (0 allowed)
//  wr_data        in   DATA_W  write word stream
//  wr_data_valid  in   1       write word available
//  wr_data_ready  out  1       high only in FETCH
//  rd_data        out  DATA_W  read word, held until next read word
//  rd_data_valid  out  1       1-cycle pulse per read word
//  xfer_done      out  1       1-cycle pulse at end of command
//  xfer_err       out  1       with xfer_done: 1 = aborted on timeout
//  mem_start      out  1       to memory start
//  mem_wr         out  1       to memory wr
//  mem_address    out  ADDR_W  to memory address
//  mem_data_in    out  DATA_W  to memory data_in
//  mem_data_out   in   DATA_W  from memory data_out
//  mem_done       in   1       from memory done
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except cmd_ready=1. Counters and
//   registers are 0. A reset mid-command drops mem_start at once and
//   discards the command.
//  States: IDLE, FETCH, REQ, RELEASE, DONE.
//  IDLE: on cmd_valid, latch addr/len/wr.
//   - len==0 -> DONE.
//   - wr=1 -> FETCH.
//   - wr=0 -> REQ.
//  FETCH: wr_data_ready=1. On wr_data_valid, register wr_data into
//   mem_data_in and go to REQ. No timeout applies here; the bench may stall.
//  REQ: mem_start=1. mem_wr, mem_address and mem_data_in are stable.
//   On mem_done==1:
//   - for reads, rd_data <= mem_data_out and rd_data_valid pulses next cycle;
//   - go to RELEASE.
//  RELEASE: mem_start=0. On mem_done==0:
//   - mem_address += 1, wrapping from 2^ADDR_W-1 to 0;
//   - remaining -= 1;
//   - if remaining == 0 -> DONE, else -> FETCH (write) or REQ (read).
//  DONE: xfer_done=1 for exactly 1 cycle, then IDLE. xfer_err is valid
//   in the same cycle.
//  Timeout: a phase counter clears on entry to REQ and to RELEASE. If it
//   reaches TIMEOUT, mem_start drops and the FSM goes to DONE with
//   xfer_err=1. The remaining words are not transferred.
//  mem_start, mem_wr, mem_address and mem_data_in are registered outputs
//   with no combinational path from inputs. mem_wr is constant for the
//   whole command.
//  Throughput: 4 cycles/word for reads against the registered-done
//   responder (REQ 2 cycles, RELEASE 2 cycles). Writes add at least 1
//   FETCH cycle.
//  cmd_valid outside IDLE is ignored; it is neither queued nor latched.
// TESTING
//  1 Read: addr=0x10, len=3, memory preloaded 0xA001/0xA002/0xA003 ->
//    3 rd_data_valid pulses, 4 cycles apart, in that order; then xfer_done=1
//    with xfer_err=0.
//  2 Write: addr=0x20, len=2, stream 0x1234, 0xBEEF -> mem_wr=1 on both
//    handshakes; read back 0x20/0x21 returns 0x1234/0xBEEF.
//  3 Wrap: read addr=0xFE, len=3 -> mem_address sequence 0xFE, 0xFF, 0x00.
//  4 Zero length: len=0 -> xfer_done 2 cycles after the accept cycle;
//    mem_start never rises.
//  5 Timeout: mem_done tied to 0, TIMEOUT=8, read len=2 -> mem_start high
//    for 8 cycles, then xfer_done=1 with xfer_err=1 and no rd_data_valid.
//  6 Reset mid-command: assert reset during REQ of word 2 of 4 ->
//    mem_start=0 immediately, cmd_ready=1 after release; a new command
//    runs normally.

Source files
------------

// File: rtl/mem_seq_master_if.sv
// Single-word memory handshake bus between the block sequencer and the memory wrapper.
// Latency: none, wires only.
// Backpressure: a four-phase start/done handshake. The master holds start until done rises, then waits for done to fall.
// Ports (master view): mem_start, mem_wr, mem_address, mem_data_in are outputs.
//                      mem_data_out and mem_done are inputs.
interface mem_seq_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_start;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_done;

    modport master (
        output mem_start, mem_wr, mem_address, mem_data_in,
        input  mem_data_out, mem_done
    );

    modport slave (
        input  mem_start, mem_wr, mem_address, mem_data_in,
        output mem_data_out, mem_done
    );
endinterface

// File: rtl/mem_seq_master.sv
// Block read/write sequencer. It turns one (addr, len, wr) command into len four-phase memory handshakes.
// Latency: 4 cycles/word for reads against a registered-done memory. Writes add at least 1 cycle to fetch each word.
// Backpressure: cmd_ready is high only in IDLE. wr_data_ready is high only while fetching. A phase stall longer than TIMEOUT aborts the command.
// Ports: clk/reset; a cmd_* command channel; a wr_data stream in; a rd_data stream out;
//        an xfer_done/xfer_err completion pulse; mem = memory bus (master modport).
module mem_seq_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_data_valid,
    output logic              wr_data_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              xfer_done,
    output logic              xfer_err,
    mem_seq_master_if.master  mem
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_REQ, ST_RELEASE, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvld_q, rvld_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              err_pend_q, err_pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              start_q, start_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic              wr_rdy_q, wr_rdy_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvld_d     = 1'b0;
        err_pend_d = err_pend_q;
        cnt_d      = cnt_q;
        // The completion pulse is registered off the DONE state, so it appears
        // the cycle after DONE, together with the abort flag of this command.
        done_d     = (state_q == ST_DONE);
        err_d      = (state_q == ST_DONE) && err_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d     = cmd_addr;
                    rem_d      = cmd_len;
                    wr_d       = cmd_wr;
                    err_pend_d = 1'b0;
                    cnt_d      = '0;
                    if (cmd_len == '0)  state_d = ST_DONE;
                    else if (cmd_wr)    state_d = ST_FETCH;
                    else                state_d = ST_REQ;
                end
            end
            ST_FETCH: begin
                if (wr_data_valid) begin
                    wdata_d = wr_data;
                    cnt_d   = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_done) begin
                    if (!wr_q) begin
                        rdata_d = mem.mem_data_out;
                        rvld_d  = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_pend_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!mem.mem_done) begin
                    addr_d = addr_q + 1'b1;   // natural wrap at 2^ADDR_W
                    rem_d  = rem_q - 1'b1;
                    cnt_d  = '0;
                    if (rem_q == LEN_W'(1)) state_d = ST_DONE;
                    else if (wr_q)          state_d = ST_FETCH;
                    else                    state_d = ST_REQ;
                end else if (cnt_q == CNT_LAST) begin
                    err_pend_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered from the next state, so each one tracks the state exactly.
        start_d   = (state_d == ST_REQ);
        cmd_rdy_d = (state_d == ST_IDLE);
        wr_rdy_d  = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rvld_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            cmd_rdy_q  <= 1'b1;
            wr_rdy_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rvld_q     <= rvld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            cmd_rdy_q  <= cmd_rdy_d;
            wr_rdy_q   <= wr_rdy_d;
        end
    end

    assign cmd_ready       = cmd_rdy_q;
    assign wr_data_ready   = wr_rdy_q;
    assign rd_data         = rdata_q;
    assign rd_data_valid   = rvld_q;
    assign xfer_done       = done_q;
    assign xfer_err        = err_q;
    assign mem.mem_start   = start_q;
    assign mem.mem_wr      = wr_q;
    assign mem.mem_address = addr_q;
    assign mem.mem_data_in = wdata_q;
endmodule

// File: tb/tb_mem_seq_master.sv
// Bench for mem_seq_master. It drives directed commands against a registered-done memory responder.
// Latency: n/a. A scoreboard monitor checks each output event against queued expectations.
// Backpressure: the write stream is offered one word at a time and waits for wr_data_ready.
module tb_mem_seq_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [7:0]  cmd_addr, cmd_len;
    logic [15:0] wr_data, rd_data;
    logic        wr_data_valid, wr_data_ready, rd_data_valid, xfer_done, xfer_err;
    logic        tie_off;

    mem_seq_master_if #(.ADDR_W(8), .DATA_W(16)) mem_bus ();

    mem_seq_master #(.ADDR_W(8), .DATA_W(16), .LEN_W(8), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_ready(wr_data_ready),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .xfer_done(xfer_done), .xfer_err(xfer_err),
        .mem(mem_bus)
    );

    always #5 clk = ~clk;

    // Memory responder: done follows start one cycle later, and the read data is registered.
    logic [15:0] memory [256];
    always @(posedge clk) begin
        mem_bus.mem_done     <= tie_off ? 1'b0 : mem_bus.mem_start;
        mem_bus.mem_data_out <= memory[mem_bus.mem_address];
        if (mem_bus.mem_start && !mem_bus.mem_done && mem_bus.mem_wr)
            memory[mem_bus.mem_address] <= mem_bus.mem_data_in;
    end

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_rd[$];
    logic [31:0] exp_addr[$];   // {wr, address} at each rising edge of mem_start
    logic [31:0] exp_done[$];   // expected xfer_err
    int start_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // Monitor/scoreboard process.
    int cyc = 0;
    initial begin
        logic prev_start;
        logic have_prev;
        int   last_rd;
        prev_start = 1'b0;
        have_prev  = 1'b0;
        last_rd    = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                prev_start = 1'b0;
                have_prev  = 1'b0;
            end else begin
                if (mem_bus.mem_start && !prev_start) begin
                    start_rises++;
                    if (exp_addr.size() == 0) fail_now("mem_addr_unexpected");
                    else check("mem_wr_addr", {23'd0, mem_bus.mem_wr, mem_bus.mem_address}, exp_addr.pop_front());
                end
                prev_start = mem_bus.mem_start;
                if (rd_data_valid) begin
                    if (exp_rd.size() == 0) fail_now("rd_unexpected");
                    else check("rd_data", {16'd0, rd_data}, exp_rd.pop_front());
                    if (have_prev) check("rd_gap", cyc - last_rd, 4);
                    have_prev = 1'b1;
                    last_rd   = cyc;
                end
                if (xfer_done) begin
                    if (exp_done.size() == 0) fail_now("done_unexpected");
                    else check("xfer_err", {31'd0, xfer_err}, exp_done.pop_front());
                    have_prev = 1'b0;
                end
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] len);
        int n;
        @(negedge clk);
        cmd_wr = wr; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) fail_now("cmd_ready_timeout");
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d);
        int n;
        wr_data = d; wr_data_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!wr_data_ready && n < 200);
        if (!wr_data_ready) fail_now("wr_data_ready_timeout");
        @(posedge clk);
        #1 wr_data_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!xfer_done && n < 300);
        if (!xfer_done) fail_now("xfer_done_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, base;
        for (int i = 0; i < 256; i++) memory[i] = 16'h0000;
        memory[8'h10] = 16'hA001; memory[8'h11] = 16'hA002; memory[8'h12] = 16'hA003;
        memory[8'hFE] = 16'h5EFE; memory[8'hFF] = 16'h5EFF; memory[8'h00] = 16'h5E00;
        memory[8'h50] = 16'hC050; memory[8'h51] = 16'hC051;
        memory[8'h52] = 16'hC052; memory[8'h53] = 16'hC053;
        reset = 1'b1; tie_off = 1'b0;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
        check("rst_mem_start", {31'd0, mem_bus.mem_start}, 0);
        check("rst_mem_wr", {31'd0, mem_bus.mem_wr}, 0);
        check("rst_mem_address", {24'd0, mem_bus.mem_address}, 0);
        check("rst_wr_data_ready", {31'd0, wr_data_ready}, 0);
        check("rst_xfer_done", {31'd0, xfer_done}, 0);
        check("rst_rd_data", {16'd0, rd_data}, 0);
        reset = 1'b0;

        // 1: read three words from 0x10.
        exp_addr.push_back(32'h010); exp_addr.push_back(32'h011); exp_addr.push_back(32'h012);
        exp_rd.push_back(32'hA001); exp_rd.push_back(32'hA002); exp_rd.push_back(32'hA003);
        exp_done.push_back(0);
        send_cmd(1'b0, 8'h10, 8'd3);
        wait_done(n);

        // 2: write two words to 0x20, then read them back.
        exp_addr.push_back(32'h120); exp_addr.push_back(32'h121);
        exp_done.push_back(0);
        send_cmd(1'b1, 8'h20, 8'd2);
        push_word(16'h1234);
        push_word(16'hBEEF);
        wait_done(n);
        exp_addr.push_back(32'h020); exp_addr.push_back(32'h021);
        exp_rd.push_back(32'h1234); exp_rd.push_back(32'hBEEF);
        exp_done.push_back(0);
        send_cmd(1'b0, 8'h20, 8'd2);
        wait_done(n);

        // 3: the address wraps from 0xFF to 0x00.
        exp_addr.push_back(32'h0FE); exp_addr.push_back(32'h0FF); exp_addr.push_back(32'h000);
        exp_rd.push_back(32'h5EFE); exp_rd.push_back(32'h5EFF); exp_rd.push_back(32'h5E00);
        exp_done.push_back(0);
        send_cmd(1'b0, 8'hFE, 8'd3);
        wait_done(n);

        // 4: a zero-length command completes 2 cycles after the accept cycle and never starts memory.
        base = start_rises;
        exp_done.push_back(0);
        send_cmd(1'b0, 8'h33, 8'd0);
        wait_done(n);
        check("zero_len_latency", n, 2);
        check("zero_len_no_start", start_rises - base, 0);

        // 5: memory never answers, so the command aborts after 8 cycles of start.
        tie_off = 1'b1;
        exp_addr.push_back(32'h040);
        exp_done.push_back(1);
        send_cmd(1'b0, 8'h40, 8'd2);
        hi = 0; n = 0;
        do begin @(negedge clk); n++; if (mem_bus.mem_start) hi++; end while (!xfer_done && n < 300);
        if (!xfer_done) fail_now("timeout_done_missing");
        check("timeout_start_cycles", hi, 8);
        tie_off = 1'b0;
        repeat (2) @(negedge clk);

        // 6: reset arrives during the REQ phase of word 2 of 4.
        exp_addr.push_back(32'h050); exp_addr.push_back(32'h051);
        exp_addr.push_back(32'h052); exp_addr.push_back(32'h053);
        exp_rd.push_back(32'hC050); exp_rd.push_back(32'hC051);
        exp_rd.push_back(32'hC052); exp_rd.push_back(32'hC053);
        exp_done.push_back(0);
        base = start_rises;
        send_cmd(1'b0, 8'h50, 8'd4);
        n = 0;
        do begin @(negedge clk); #2; n++; end while (start_rises < base + 2 && n < 100);
        check("reset_mid_word2_reached", start_rises - base, 2);
        reset = 1'b1;
        #1;
        check("reset_mem_start_drop", {31'd0, mem_bus.mem_start}, 0);
        exp_rd.delete(); exp_addr.delete(); exp_done.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_cmd_ready", {31'd0, cmd_ready}, 1);
        exp_addr.push_back(32'h010);
        exp_rd.push_back(32'hA001);
        exp_done.push_back(0);
        send_cmd(1'b0, 8'h10, 8'd1);
        wait_done(n);

        repeat (3) @(negedge clk);
        check("left_rd", exp_rd.size(), 0);
        check("left_addr", exp_addr.size(), 0);
        check("left_done", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
